stream_merger: RTL

STREAM_MERGER -- requirements
Module: stream_merger

---
 rtl/stream_merger_if.sv | 15 +
 rtl/stream_merger.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/stream_merger_if.sv
// AXI-Stream bundle shared by the merger's aggregation, bypass and merged ports.
interface stream_merger_if #(
  parameter int DATA_WIDTH = 256,
  parameter int USER_WIDTH = 128
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic [USER_WIDTH-1:0]   tuser;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/stream_merger.sv
// Packet-atomic round-robin merge of the aggregation-return and bypass streams
// into one registered AXI-Stream output, with per-source completed-packet counters.
module stream_merger #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128
) (
  input  logic            axis_aclk,
  input  logic            axis_resetn,
  stream_merger_if.slave  s_axis_agg,
  stream_merger_if.slave  s_axis_byp,
  stream_merger_if.master m_axis,
  output logic [31:0]     pkt_agg_cnt,
  output logic [31:0]     pkt_byp_cnt
);

  localparam int KEEP_WIDTH = C_AXIS_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_AGG = 2'd1,
    SEND_BYP = 2'd2
  } state_t;

  typedef enum logic {
    SRC_AGG = 1'b0,
    SRC_BYP = 1'b1
  } src_t;

  state_t state_q, state_d;
  src_t   last_grant_q, last_grant_d;

  logic grant_agg, grant_byp;
  logic accept_agg, accept_byp, accept;
  logic out_ready;

  logic [C_AXIS_DATA_WIDTH-1:0]  sel_tdata;
  logic [KEEP_WIDTH-1:0]         sel_tkeep;
  logic [C_AXIS_TUSER_WIDTH-1:0] sel_tuser;
  logic                          sel_tlast;
  src_t                          sel_src;

  logic [C_AXIS_DATA_WIDTH-1:0]  out_tdata_q;
  logic [KEEP_WIDTH-1:0]         out_tkeep_q;
  logic [C_AXIS_TUSER_WIDTH-1:0] out_tuser_q;
  logic                          out_tlast_q;
  logic                          out_tvalid_q;
  src_t                          out_src_q;
  logic                          out_last_xfer;

  // The output slot can take a beat when it is empty or draining this cycle;
  // reset also blocks both sources so nothing is accepted while held in reset.
  assign out_ready = axis_resetn & (m_axis.tready | ~out_tvalid_q);

  assign s_axis_agg.tready = grant_agg & out_ready;
  assign s_axis_byp.tready = grant_byp & out_ready;

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q      <= IDLE;
      last_grant_q <= SRC_BYP;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    grant_agg    = 1'b0;
    grant_byp    = 1'b0;
    state_d      = state_q;
    last_grant_d = last_grant_q;

    case (state_q)
      IDLE: begin
        if (s_axis_agg.tvalid && (!s_axis_byp.tvalid || last_grant_q == SRC_BYP))
          grant_agg = 1'b1;
        else if (s_axis_byp.tvalid)
          grant_byp = 1'b1;
      end
      SEND_AGG: grant_agg = 1'b1;
      SEND_BYP: grant_byp = 1'b1;
      default:  state_d = IDLE;
    endcase

    accept_agg = grant_agg & s_axis_agg.tvalid & out_ready;
    accept_byp = grant_byp & s_axis_byp.tvalid & out_ready;
    accept     = accept_agg | accept_byp;

    // Single-beat packets never leave IDLE; longer packets lock their source.
    if (state_q == IDLE) begin
      if (accept_agg && !s_axis_agg.tlast)
        state_d = SEND_AGG;
      else if (accept_byp && !s_axis_byp.tlast)
        state_d = SEND_BYP;
    end else if ((accept_agg && s_axis_agg.tlast) || (accept_byp && s_axis_byp.tlast)) begin
      state_d = IDLE;
    end

    if (accept_agg && s_axis_agg.tlast)
      last_grant_d = SRC_AGG;
    else if (accept_byp && s_axis_byp.tlast)
      last_grant_d = SRC_BYP;
  end

  always_comb begin
    sel_tdata = s_axis_agg.tdata;
    sel_tkeep = s_axis_agg.tkeep;
    sel_tuser = s_axis_agg.tuser;
    sel_tlast = s_axis_agg.tlast;
    sel_src   = SRC_AGG;
    if (grant_byp) begin
      sel_tdata = s_axis_byp.tdata;
      sel_tkeep = s_axis_byp.tkeep;
      sel_tuser = s_axis_byp.tuser;
      sel_tlast = s_axis_byp.tlast;
      sel_src   = SRC_BYP;
    end
  end

  // Output stage holds under backpressure and is tagged with the beat's source
  // so the completed-packet counters can be attributed at the output.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      out_tdata_q  <= '0;
      out_tkeep_q  <= '0;
      out_tuser_q  <= '0;
      out_tlast_q  <= 1'b0;
      out_tvalid_q <= 1'b0;
      out_src_q    <= SRC_AGG;
    end else if (accept) begin
      out_tdata_q  <= sel_tdata;
      out_tkeep_q  <= sel_tkeep;
      out_tuser_q  <= sel_tuser;
      out_tlast_q  <= sel_tlast;
      out_tvalid_q <= 1'b1;
      out_src_q    <= sel_src;
    end else if (m_axis.tready) begin
      out_tvalid_q <= 1'b0;
    end
  end

  assign m_axis.tdata  = out_tdata_q;
  assign m_axis.tkeep  = out_tkeep_q;
  assign m_axis.tuser  = out_tuser_q;
  assign m_axis.tlast  = out_tlast_q;
  assign m_axis.tvalid = out_tvalid_q;

  assign out_last_xfer = out_tvalid_q & m_axis.tready & out_tlast_q;

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      pkt_agg_cnt <= 32'd0;
      pkt_byp_cnt <= 32'd0;
    end else if (out_last_xfer) begin
      if (out_src_q == SRC_AGG)
        pkt_agg_cnt <= pkt_agg_cnt + 32'd1;
      else
        pkt_byp_cnt <= pkt_byp_cnt + 32'd1;
    end
  end

endmodule
